// File: rtl/xor_desc_pkg.sv
// Shared constants and FSM encoding for the XOR descrambler slice.
package xor_desc_pkg;

  localparam int unsigned WIDTH        = 16;
  localparam logic [15:0] POLY         = 16'hB400;  // x^16+x^14+x^13+x^11+1
  localparam logic [15:0] SEED_DEFAULT = 16'hACE1;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/lfsr16_adv16.sv
// Combinational 16-step advance of a 16-bit Galois LFSR (right-shifting form).
module lfsr16_adv16 #(
  parameter logic [15:0] POLY = xor_desc_pkg::POLY
) (
  input  logic [15:0] state_i,
  output logic [15:0] state_o
);

  // Unrolled chain of 16 single Galois steps
  always_comb begin
    logic [15:0] s;
    s = state_i;
    for (int unsigned i = 0; i < 16; i++) begin
      s = s[0] ? ({1'b0, s[15:1]} ^ POLY) : {1'b0, s[15:1]};
    end
    state_o = s;
  end

endmodule

// File: rtl/xor_descrambler_16.sv
// XOR descrambler: out_data = in_data ^ LFSR keystream, valid/ready both sides,
// 1-cycle latency, full throughput.
// Optional feature: define XOR_DESCRAMBLER_PARITY_EN to add in_parity/parity_err
// (sticky even-parity check over each accepted scrambled word).
module xor_descrambler_16 #(
  parameter int unsigned WIDTH        = xor_desc_pkg::WIDTH,  // only 16 supported
  parameter logic [15:0] POLY         = xor_desc_pkg::POLY,
  parameter logic [15:0] SEED_DEFAULT = xor_desc_pkg::SEED_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed_in,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             running,
  output logic [15:0]      word_count
`ifdef XOR_DESCRAMBLER_PARITY_EN
  ,
  input  logic             in_parity,
  output logic             parity_err
`endif
);

  import xor_desc_pkg::*;

  state_e           state_q, state_d;
  logic [15:0]      lfsr_q, lfsr_d, lfsr_adv;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [15:0]      word_count_q, word_count_d;
  logic [15:0]      seed_eff;
  logic             accept;

  lfsr16_adv16 #(.POLY(POLY)) u_adv (
    .state_i (lfsr_q),
    .state_o (lfsr_adv)
  );

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // FSM next state: any seed load enters (or stays in) RUN
  always_comb begin
    state_d = state_q;
    if (seed_load) state_d = RUN;
  end

  // FSM outputs: ready only when seeded and the output slot is free or draining
  always_comb begin
    running  = (state_q == RUN);
    in_ready = running && (!out_valid_q || out_ready);
  end

  assign seed_eff = (seed_in == '0) ? SEED_DEFAULT : seed_in;
  // seed_load suppresses acceptance even when in_ready is high
  assign accept   = in_valid && in_ready && !seed_load;

  // Datapath next state: seed load > accept > drain
  always_comb begin
    lfsr_d       = lfsr_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    word_count_d = word_count_q;
    if (seed_load) begin
      lfsr_d       = seed_eff;
      out_valid_d  = 1'b0;
      word_count_d = '0;
    end else if (accept) begin
      out_data_d   = in_data ^ lfsr_q;
      out_valid_d  = 1'b1;
      lfsr_d       = lfsr_adv;
      word_count_d = word_count_q + 16'd1;
    end else if (out_valid_q && out_ready) begin
      out_valid_d  = 1'b0;
    end
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q       <= SEED_DEFAULT;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      word_count_q <= '0;
    end else begin
      lfsr_q       <= lfsr_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      word_count_q <= word_count_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign word_count = word_count_q;

`ifdef XOR_DESCRAMBLER_PARITY_EN
  logic parity_err_q, parity_err_d;

  // Sticky parity error, cleared by reseeding
  always_comb begin
    parity_err_d = parity_err_q;
    if (seed_load)                                   parity_err_d = 1'b0;
    else if (accept && ((^in_data) != in_parity))    parity_err_d = 1'b1;
  end

  // Parity error register
  always_ff @(posedge clk) begin
    if (rst) parity_err_q <= 1'b0;
    else     parity_err_q <= parity_err_d;
  end

  assign parity_err = parity_err_q;
`endif

endmodule
